// File: rtl/main_memory_responder.sv
// Word-addressed RAM slave that closes the RD/WR -> ACK handshake of the control unit.
// Optional misaligned-access detection is enabled by defining MAIN_MEMORY_RESPONDER_ALIGN_CHECK_EN.
module main_memory_responder #(
  parameter int unsigned DATAWIDTH_BUS   = 32,
  parameter int unsigned ADDR_WIDTH      = 10,
  parameter int unsigned WAIT_STATES     = 2,
  parameter int unsigned DATAWIDTH_COUNT = 4
) (
  input  logic                     main_memory_responder_CLOCK_50,
  input  logic                     main_memory_responder_RESET_InHigh,
  input  logic                     main_memory_responder_RD,
  input  logic                     main_memory_responder_WR,
  input  logic [DATAWIDTH_BUS-1:0] main_memory_responder_ADDR_InBUS,
  input  logic [DATAWIDTH_BUS-1:0] main_memory_responder_DATA_InBUS,
  output logic [DATAWIDTH_BUS-1:0] main_memory_responder_DATA_OutBUS,
  output logic                     main_memory_responder_ACK,
  output logic                     main_memory_responder_BUSY,
  output logic                     main_memory_responder_ERROR
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

  state_t                     state, next_state;
  logic [DATAWIDTH_COUNT-1:0] cnt, next_cnt;
  logic                       latch_en, access_c;

  logic                       lat_wr;
  logic [ADDR_WIDTH-1:0]      lat_idx;
  logic [DATAWIDTH_BUS-1:0]   lat_data;

  logic                       cur_wr, cur_mis, mem_we, mem_re;
  logic [ADDR_WIDTH-1:0]      cur_idx;
  logic [DATAWIDTH_BUS-1:0]   cur_data;

  logic [DATAWIDTH_BUS-1:0]   mem [DEPTH];

  wire req_c = main_memory_responder_RD | main_memory_responder_WR;
  wire [ADDR_WIDTH-1:0] in_idx_c = main_memory_responder_ADDR_InBUS[ADDR_WIDTH+1:2];
  wire unused_addr_bits = ^{main_memory_responder_ADDR_InBUS[DATAWIDTH_BUS-1:ADDR_WIDTH+2],
                            main_memory_responder_ADDR_InBUS[1:0]};

  // Next-state and wait-state counter
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    latch_en   = 1'b0;
    access_c   = 1'b0;
    case (state)
      S_IDLE: begin
        if (req_c) begin
          latch_en = 1'b1;
          if (WAIT_STATES == 0) begin
            next_state = S_ACK;
            access_c   = 1'b1;
          end else begin
            next_state = S_WAIT;
            next_cnt   = DATAWIDTH_COUNT'(WAIT_STATES - 1);
          end
        end
      end
      S_WAIT: begin
        if (cnt == '0) begin
          next_state = S_ACK;
          access_c   = 1'b1;
        end else begin
          next_cnt = cnt - 1'b1;
        end
      end
      S_ACK:   next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // With zero wait states the access happens on the sampling edge, so bypass the latches
  always_comb begin
    cur_wr   = (state == S_IDLE) ? main_memory_responder_WR       : lat_wr;
    cur_idx  = (state == S_IDLE) ? in_idx_c                       : lat_idx;
    cur_data = (state == S_IDLE) ? main_memory_responder_DATA_InBUS : lat_data;
  end

`ifdef MAIN_MEMORY_RESPONDER_ALIGN_CHECK_EN
  logic lat_mis;

  always_ff @(posedge main_memory_responder_CLOCK_50) begin
    if (main_memory_responder_RESET_InHigh) lat_mis <= 1'b0;
    else if (latch_en)                      lat_mis <= |main_memory_responder_ADDR_InBUS[1:0];
  end

  assign cur_mis = (state == S_IDLE) ? |main_memory_responder_ADDR_InBUS[1:0] : lat_mis;
`else
  assign cur_mis = 1'b0;
`endif

  assign mem_we = access_c & cur_wr & ~cur_mis;
  assign mem_re = access_c & ~cur_wr & ~cur_mis;

  // State, request latches and registered outputs
  always_ff @(posedge main_memory_responder_CLOCK_50) begin
    if (main_memory_responder_RESET_InHigh) begin
      state                             <= S_IDLE;
      cnt                               <= '0;
      lat_wr                            <= 1'b0;
      lat_idx                           <= '0;
      lat_data                          <= '0;
      main_memory_responder_ACK         <= 1'b0;
      main_memory_responder_BUSY        <= 1'b0;
      main_memory_responder_ERROR       <= 1'b0;
      main_memory_responder_DATA_OutBUS <= '0;
    end else begin
      state                       <= next_state;
      cnt                         <= next_cnt;
      main_memory_responder_ACK   <= (next_state == S_ACK);
      main_memory_responder_BUSY  <= (next_state != S_IDLE);
      main_memory_responder_ERROR <= access_c & cur_mis;
      if (latch_en) begin
        lat_wr   <= main_memory_responder_WR;
        lat_idx  <= in_idx_c;
        lat_data <= main_memory_responder_DATA_InBUS;
      end
      if (mem_re) main_memory_responder_DATA_OutBUS <= mem[cur_idx];
    end
  end

  // RAM array is deliberately not reset; a reset edge suppresses a pending write
  always_ff @(posedge main_memory_responder_CLOCK_50) begin
    if (!main_memory_responder_RESET_InHigh && mem_we) mem[cur_idx] <= cur_data;
  end

endmodule

// File: tb/tb_main_memory_responder.sv
// Directed bench for main_memory_responder with default parameters (2 wait states).
// Expectations for the misaligned write follow MAIN_MEMORY_RESPONDER_ALIGN_CHECK_EN.
module tb_main_memory_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd  = 1'b0;
  logic        wr  = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] din  = '0;
  logic [31:0] dout;
  logic        ack, busy, error;

  int n_cmp = 0;
  int n_bad = 0;

  main_memory_responder dut (
    .main_memory_responder_CLOCK_50    (clk),
    .main_memory_responder_RESET_InHigh(rst),
    .main_memory_responder_RD          (rd),
    .main_memory_responder_WR          (wr),
    .main_memory_responder_ADDR_InBUS  (addr),
    .main_memory_responder_DATA_InBUS  (din),
    .main_memory_responder_DATA_OutBUS (dout),
    .main_memory_responder_ACK         (ack),
    .main_memory_responder_BUSY        (busy),
    .main_memory_responder_ERROR       (error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One transaction: drive, count edges until ACK, release, settle back to IDLE
  task automatic xfer(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                      output int lat, output logic err, output logic busy_all);
    rd = r; wr = w; addr = a; din = d;
    lat = 0; busy_all = 1'b1;
    do begin
      tick();
      lat++;
      if (!ack) busy_all &= busy;
    end while (!ack && lat < 20);
    err = error;
    rd = 1'b0; wr = 1'b0;
    tick();
  endtask

  int          lat, cnt;
  logic        err, ball, no_ack;

  initial begin
    // Reset state
    repeat (2) tick();
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_dout", dout, 32'h0);
    rst = 1'b0;
    tick();

    // Write then read same address
    xfer(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, lat, err, ball);
    chk("wr_latency", 32'(lat), 32'd3);
    chk("wr_busy", 32'(ball), 32'd1);
    chk("wr_ack_pulse", 32'(ack), 32'd0);
    chk("wr_busy_after", 32'(busy), 32'd0);
    chk("wr_dout_kept", dout, 32'h0);
    xfer(1'b1, 1'b0, 32'h10, 32'h0, lat, err, ball);
    chk("rd_latency", 32'(lat), 32'd3);
    chk("rd_busy", 32'(ball), 32'd1);
    chk("rd_data", dout, 32'hDEAD_BEEF);

    // Aliasing: upper address bits ignored
    xfer(1'b1, 1'b0, 32'h0000_1010, 32'h0, lat, err, ball);
    chk("alias_data", dout, 32'hDEAD_BEEF);

    // Prefill words 0,1,2 then stream reads with RD held high
    for (int i = 0; i < 3; i++) xfer(1'b0, 1'b1, 32'(i * 4), 32'(i + 1), lat, err, ball);
    rd = 1'b1; addr = 32'h0;
    for (int i = 0; i < 3; i++) begin
      cnt = 0;
      do begin
        tick();
        cnt++;
      end while (!ack && cnt < 20);
      chk($sformatf("stream_data%0d", i), dout, 32'(i + 1));
      chk($sformatf("stream_period%0d", i), 32'(cnt), (i == 0) ? 32'd3 : 32'd4);
      addr = 32'((i + 1) * 4);
    end
    rd = 1'b0;
    tick();

    // Address change during WAIT is ignored
    rd = 1'b1; addr = 32'h4;
    tick();
    addr = 32'h8;
    cnt = 1;
    while (!ack && cnt < 20) begin
      tick();
      cnt++;
    end
    rd = 1'b0;
    chk("wait_addr_latched", dout, 32'h2);
    tick();

    // RD and WR together: write wins, DATA_OutBUS untouched
    xfer(1'b1, 1'b1, 32'h20, 32'h5A5A_5A5A, lat, err, ball);
    chk("rdwr_dout_kept", dout, 32'h2);
    xfer(1'b1, 1'b0, 32'h20, 32'h0, lat, err, ball);
    chk("rdwr_readback", dout, 32'h5A5A_5A5A);

    // Reset during WAIT drops the pending write
    xfer(1'b0, 1'b1, 32'h40, 32'hFFFF_0000, lat, err, ball);
    wr = 1'b1; addr = 32'h40; din = 32'h0000_1234;
    tick();
    chk("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1; wr = 1'b0;
    tick();
    chk("midrst_ack", 32'(ack), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    no_ack = 1'b1;
    repeat (4) begin
      tick();
      no_ack &= ~ack;
    end
    chk("midrst_no_ack", 32'(no_ack), 32'd1);
    xfer(1'b1, 1'b0, 32'h40, 32'h0, lat, err, ball);
    chk("midrst_readback", dout, 32'hFFFF_0000);

    // Misaligned write to 0x42
    xfer(1'b0, 1'b1, 32'h42, 32'hCAFE_F00D, lat, err, ball);
    chk("mis_latency", 32'(lat), 32'd3);
`ifdef MAIN_MEMORY_RESPONDER_ALIGN_CHECK_EN
    chk("mis_error", 32'(err), 32'd1);
    chk("mis_error_drop", 32'(error), 32'd0);
    xfer(1'b1, 1'b0, 32'h40, 32'h0, lat, err, ball);
    chk("mis_readback", dout, 32'hFFFF_0000);
`else
    chk("mis_error", 32'(err), 32'd0);
    chk("mis_error_drop", 32'(error), 32'd0);
    xfer(1'b1, 1'b0, 32'h40, 32'h0, lat, err, ball);
    chk("mis_readback", dout, 32'hCAFE_F00D);
`endif
    chk("rd_error", 32'(err), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
